mdu_iter: RTL
=============

Name: mdu_iter

Overview:
Iterative multiply/divide unit with HI/LO result registers. It serves the MIPS-style core alongside the combinational ALU.
- Handles MULT/MULTU/DIV/DIVU, which the single-cycle ALU cannot.
- Parametrised in data width. Radix-2 shift-add multiply, restoring divide.
- Start/busy/done handshake to the pipeline control. The pipeline reads HI/LO directly (mfhi/mflo).

Parameters:
W, 32, operand width; HI and LO are W bits each; W >= 4
CNT_W, $clog2(W)+1, iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; others no-op
rs  in  W  operand A / dividend / MTHI-MTLO source
rt  in  W  operand B / divisor
flush  in  1  synchronous abort of an in-flight operation
busy  out  1  high from the cycle after accept until done
done  out  1  one-cycle pulse: HI/LO valid with new result
hi  out  W  HI register
lo  out  W  LO register
div_by_zero  out  1  set with done of a DIV/DIVU whose rt==0; cleared on next accepted start

Behaviour:
- Reset (async, rst_n=0): state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0. Reset mid-operation discards all work.
- States: IDLE -> CALC -> FIXUP -> IDLE. done is a registered pulse emitted on the FIXUP->IDLE edge.
- Accept: start=1 in IDLE with op 0..3 at edge E0.
  - Operands are latched as magnitudes (signed ops) or raw values (unsigned ops); result sign is recorded.
  - Counter is loaded with W; busy=1 from E0.
- CALC: one bit per cycle.
  - Multiply: conditional add then right shift of the 2W product.
  - Divide: left shift, trial subtract, quotient bit set.
  - Counter decrements to 0; then go to FIXUP.
- FIXUP:
  - Apply sign: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
  - Write hi/lo; done=1 and busy=0 on the following edge.
- Latency: accept edge to done high = W+2 cycles (34 for W=32). hi/lo change only in the done cycle.
- MTHI/MTLO: accepted in IDLE.
  - hi (or lo) <= rs at E0; done pulses at E0+1; busy stays 0.
  - div_by_zero is cleared.
- start while busy: ignored, no queueing. op 6/7: ignored, no done.
- Divide by zero: runs full latency; lo={W{1'b1}}, hi=rs (original, signed), div_by_zero=1.
- Signed overflow (DIV of MIN by -1): lo=MIN, hi=0, no flag.
- flush=1 in CALC/FIXUP: next state IDLE, busy=0, no done, hi/lo unchanged. flush in IDLE has no effect. flush and start in the same IDLE cycle: start wins.
- All arithmetic is internally W+1 bits for the trial subtract. The product accumulator is 2W+1 bits for the carry.

Optional Feature:
Macro MDU_EARLY_TERM_EN.
- Defined: multiply leaves CALC as soon as the remaining unshifted multiplier bits are all zero; the product is pre-aligned by the remaining shift count in FIXUP.
  - Minimum multiply latency is 3 cycles; MULTU 5*7 gives done at accept+5.
  - Divide timing is unchanged.
- Undefined: fixed W+2 latency for all ops. Results are bit-identical in both builds.

Decomposition:
- Package mdu_pkg holds:
  - the op encoding enum (MDU_MULT..MDU_MTLO);
  - the state enum (IDLE, CALC, FIXUP);
  - a function for two's-complement magnitude/negate.
- Single module; no sub-module is warranted. The datapath is one shared shift register plus one adder/subtractor.

Test Plan:
- MULT rs=3, rt=-36 (W=32) -> done at accept+34, hi=0xFFFFFFFF, lo=0xFFFFFF94, busy low after.
- MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; with MDU_EARLY_TERM_EN, MULTU 5*7 -> lo=35, hi=0, done at accept+5.
- DIV rs=-37, rt=3 -> lo=0xFFFFFFF4 (-12), hi=0xFFFFFFFF (-1); DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- DIVU rs=100, rt=0 -> lo=0xFFFFFFFF, hi=100, div_by_zero=1; following MTLO rs=7 -> lo=7, div_by_zero=0, done at accept+1, busy never high.
- MULT started, second start at accept+5 with different operands -> ignored, first result returned; flush at accept+10 of a new DIV -> no done, hi/lo retain prior values, next start accepted immediately.
- rst_n pulsed low mid-CALC (asynchronously, between edges) -> hi/lo/busy/done zero immediately; post-reset MULT 2*2 gives lo=4.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op/state encodings and two's-complement helper for mdu_iter
package mdu_pkg;

    // Widest vector the negate helper handles (2*W for the product)
    localparam int MDU_MAX_W = 128;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } mdu_state_e;

    // Conditional two's-complement negate; low bits of the result depend only on low bits of x
    function automatic logic [MDU_MAX_W-1:0] cond_neg(input logic [MDU_MAX_W-1:0] x, input logic en);
        return en ? ('0 - x) : x;
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative MULT/DIV unit with HI/LO registers; optional MDU_EARLY_TERM_EN
module mdu_iter
    import mdu_pkg::*;
#(
    parameter  int W     = 32,
    localparam int CNT_W = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] rs,
    input  logic [W-1:0] rt,
    input  logic         flush,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         div_by_zero
);

    mdu_state_e state_q, state_d;

    // Shared shift register: multiply {acc, multiplier}, divide {remainder, dividend/quotient}
    logic [2*W:0]     acc_q;
    logic [W-1:0]     opnd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             is_div_q, res_neg_q, rem_neg_q, dz_q, mt_pend_q;

    logic             accept, accept_mt, sgn_op, a_neg, b_neg;
    logic             early, step, finish, div_ok;
    logic [W-1:0]     a_mag, b_mag, quot, rem;
    logic [W:0]       alu_a, alu_b;
    logic [W+1:0]     alu_s;
    logic [2*W:0]     div_sh, acc_next;
    logic [2*W-1:0]   prod_raw, prod;

    function automatic logic [W-1:0] neg_w(input logic [W-1:0] x, input logic en);
        logic [MDU_MAX_W-1:0] t;
        t        = '0;
        t[W-1:0] = x;
        t        = cond_neg(t, en);
        return t[W-1:0];
    endfunction

    function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] x, input logic en);
        logic [MDU_MAX_W-1:0] t;
        t          = '0;
        t[2*W-1:0] = x;
        t          = cond_neg(t, en);
        return t[2*W-1:0];
    endfunction

    assign accept    = start && (state_q == IDLE) && !op[2];
    assign accept_mt = start && (state_q == IDLE) && (op == MDU_MTHI || op == MDU_MTLO);
    assign sgn_op    = (op == MDU_MULT) || (op == MDU_DIV);
    assign a_neg     = sgn_op && rs[W-1];
    assign b_neg     = sgn_op && rt[W-1];
    assign a_mag     = neg_w(rs, a_neg);
    assign b_mag     = neg_w(rt, b_neg);

`ifdef MDU_EARLY_TERM_EN
    // At least one iteration runs, then stop once the unshifted multiplier bits are all zero
    assign early = !is_div_q && (cnt_q != CNT_W'(W))
                 && ((acc_q[W-1:0] & ~({W{1'b1}} << cnt_q)) == '0);
`else
    assign early = 1'b0;
`endif

    assign step   = (state_q == CALC) && !flush && (cnt_q != '0) && !early;
    assign finish = (state_q == FIXUP) && !flush;

    // One adder: conditional add for multiply, trial subtract (a + ~b + 1) for divide
    always_comb begin
        div_sh = acc_q << 1;
        alu_a  = is_div_q ? div_sh[2*W:W] : acc_q[2*W:W];
        alu_b  = is_div_q ? ~{1'b0, opnd_q} : (acc_q[0] ? {1'b0, opnd_q} : '0);
        alu_s  = {1'b0, alu_a} + {1'b0, alu_b} + (W+2)'(is_div_q);
        div_ok = alu_s[W+1];
        if (is_div_q)
            acc_next = div_ok ? {alu_s[W:0], div_sh[W-1:1], 1'b1} : div_sh;
        else
            acc_next = {1'b0, alu_s[W:0], acc_q[W-1:1]};
    end

    // Sign fixup and result selection consumed on the FIXUP edge
    always_comb begin
`ifdef MDU_EARLY_TERM_EN
        prod_raw = acc_q[2*W-1:0] >> cnt_q;
`else
        prod_raw = acc_q[2*W-1:0];
`endif
        prod = neg_2w(prod_raw, res_neg_q);
        quot = dz_q ? '1 : neg_w(acc_q[W-1:0], res_neg_q);
        rem  = neg_w(acc_q[2*W-1:W], rem_neg_q);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: flush aborts CALC/FIXUP, start wins in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    if (flush) state_d = IDLE;
                     else if ((cnt_q == '0) || early) state_d = FIXUP;
            FIXUP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath, counter, HI/LO and handshake registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            opnd_q      <= '0;
            cnt_q       <= '0;
            is_div_q    <= 1'b0;
            res_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
            dz_q        <= 1'b0;
            mt_pend_q   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done      <= finish || mt_pend_q;
            mt_pend_q <= accept_mt;
            if (accept) begin
                acc_q       <= {{(W+1){1'b0}}, (op[1] ? a_mag : b_mag)};
                opnd_q      <= op[1] ? b_mag : a_mag;
                cnt_q       <= CNT_W'(W);
                is_div_q    <= op[1];
                res_neg_q   <= a_neg ^ b_neg;
                rem_neg_q   <= a_neg;
                dz_q        <= op[1] && (rt == '0);
                busy        <= 1'b1;
                div_by_zero <= 1'b0;
            end else if (accept_mt) begin
                if (op == MDU_MTHI) hi <= rs;
                else                lo <= rs;
                div_by_zero <= 1'b0;
            end
            if (step) begin
                acc_q <= acc_next;
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (finish) begin
                hi          <= is_div_q ? rem  : prod[2*W-1:W];
                lo          <= is_div_q ? quot : prod[W-1:0];
                busy        <= 1'b0;
                div_by_zero <= dz_q;
            end
            if (flush && (state_q != IDLE)) busy <= 1'b0;
        end
    end

endmodule
